reg_bank_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for one shared WIDTH-bit register of positive-edge D flip-flops.
- N requesters compete to load the register. The block grants one requester at a time, captures its data into the shared register, and returns a one-cycle acknowledge.
- Sits between lab-level requester logic and the shared storage element; it is the only writer of that register.

---
 rtl/reg_bank_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit
// register. One requester at a time is granted, its data slice is captured
// into the shared register, and a one-cycle acknowledge is returned. Each
// write takes exactly three clock edges: grant (IDLE->WRITE), capture
// (WRITE->ACK), acknowledge (ACK->IDLE).
//
// Ports:
//   Clock    in   1        system clock, rising-edge active
//   Reset    in   1        asynchronous active-high reset
//   req      in   N        request lines, req[i] = requester i wants to write
//   wdata    in   N*WIDTH  packed data, requester i at wdata[i*WIDTH +: WIDTH]
//   lock     in   N        (only with REG_BANK_ARB_LOCK_EN) keep priority
//   grant    out  N        one-hot grant, zero when idle
//   ack      out  N        one-hot, one-cycle write-complete pulse
//   Q        out  WIDTH    shared register contents
//   busy     out  1        high whenever a transaction is in progress
//   last_id  out  IDW      index of the most recently written requester
//
// Optional feature macro: REG_BANK_ARB_LOCK_EN
//   Adds the lock port. A locked requester keeps top priority for up to four
//   consecutive writes before the pointer is forced past it.
// ---------------------------------------------------------------------------
module reg_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDW   = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
`ifdef REG_BANK_ARB_LOCK_EN
    input  logic [N-1:0]       lock,
`endif
    output logic [N-1:0]       grant,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   Q,
    output logic               busy,
    output logic [IDW-1:0]     last_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win_q, win_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   ptr_next;

`ifdef REG_BANK_ARB_LOCK_EN
    logic [1:0]       run_q, run_d;
`endif

    // Winner search: walk from ptr upward with wrap. The loop runs from the
    // farthest offset down to zero so the closest requester overwrites.
    always_comb begin
        int idx;
        pick_id = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) pick_id = IDW'(idx);
        end
    end

    // Pointer value that makes the just-served requester lowest priority.
    always_comb begin
        int nxt;
        nxt = int'(win_q) + 1;
        if (nxt >= N) nxt = 0;
        ptr_next = IDW'(nxt);
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; req only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != '0) state_d = WRITE;
            WRITE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values. ack defaults low so the pulse set on the
    // ACK edge clears on the following edge.
    always_comb begin
        grant_d   = grant_q;
        ack_d     = '0;
        data_d    = data_q;
        last_id_d = last_id_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
`ifdef REG_BANK_ARB_LOCK_EN
        run_d     = run_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    win_d   = pick_id;
                    grant_d = ONE_N << pick_id;
`ifdef REG_BANK_ARB_LOCK_EN
                    // A different winner breaks any locked run.
                    if (pick_id != win_q) run_d = '0;
`endif
                end
            end
            WRITE: begin
                data_d    = wdata[int'(win_q)*WIDTH +: WIDTH];
                last_id_d = win_q;
            end
            ACK: begin
                ack_d   = ONE_N << win_q;
                grant_d = '0;
`ifdef REG_BANK_ARB_LOCK_EN
                // Hold the pointer for at most four locked writes in a row.
                if (lock[win_q] && run_q != 2'd3) begin
                    run_d = run_q + 2'd1;
                end else begin
                    run_d = '0;
                    ptr_d = ptr_next;
                end
`else
                ptr_d = ptr_next;
`endif
            end
            default: grant_d = '0;
        endcase
    end

    // Registered outputs and arbitration state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            grant_q   <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            last_id_q <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
`ifdef REG_BANK_ARB_LOCK_EN
            run_q     <= '0;
`endif
        end else begin
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            last_id_q <= last_id_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
`ifdef REG_BANK_ARB_LOCK_EN
            run_q     <= run_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign ack     = ack_q;
    assign Q       = data_q;
    assign busy    = (state_q != IDLE);
    assign last_id = last_id_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//
// Directed bench for reg_bank_arbiter. A transaction-level reference model
// tracks each write as a countdown of remaining edges and produces the
// expected grant/ack/Q/busy/last_id every cycle; a negedge process compares
// the DUT against it. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int IDW   = 2;

    logic               Clock;
    logic               Reset;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       lock;
    logic [N-1:0]       grant;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   Q;
    logic               busy;
    logic [IDW-1:0]     last_id;

    int vectors = 0;
    int errors  = 0;

    reg_bank_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .req     (req),
        .wdata   (wdata),
`ifdef REG_BANK_ARB_LOCK_EN
        .lock    (lock),
`endif
        .grant   (grant),
        .ack     (ack),
        .Q       (Q),
        .busy    (busy),
        .last_id (last_id)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: a transaction is "cycles left" 2 after grant, 1 after
    // capture, 0 when idle again. Winner = nearest requester at or after ptr.
    int             m_left;
    int             m_ptr;
    int             m_win;
    int             m_run;
    logic [N-1:0]   m_grant;
    logic [N-1:0]   m_ack;
    logic [WIDTH-1:0] m_q;
    logic           m_busy;
    int             m_last;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_left = 0; m_ptr = 0; m_win = 0; m_run = 0;
            m_grant = '0; m_ack = '0; m_q = '0; m_busy = 1'b0; m_last = 0;
        end else begin
            m_ack = '0;
            if (m_left == 0) begin
                if (req != '0) begin
                    int w;
                    bit found;
                    w = 0;
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && req[(m_ptr + k) % N]) begin
                            w = (m_ptr + k) % N;
                            found = 1'b1;
                        end
                    end
                    if (w != m_win) m_run = 0;
                    m_win   = w;
                    m_grant = 4'b0001 << w;
                    m_busy  = 1'b1;
                    m_left  = 2;
                end
            end else if (m_left == 2) begin
                m_q    = wdata[m_win*WIDTH +: WIDTH];
                m_last = m_win;
                m_left = 1;
            end else begin
                m_ack   = 4'b0001 << m_win;
                m_grant = '0;
                m_busy  = 1'b0;
                m_left  = 0;
`ifdef REG_BANK_ARB_LOCK_EN
                if (lock[m_win] && m_run + 1 < 4) begin
                    m_run = m_run + 1;
                end else begin
                    m_run = 0;
                    m_ptr = (m_win + 1) % N;
                end
`else
                m_ptr = (m_win + 1) % N;
`endif
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus structural invariants.
    always @(negedge Clock) begin
        if (!Reset) begin
            check_output("model_grant", 32'(grant), 32'(m_grant));
            check_output("model_ack", 32'(ack), 32'(m_ack));
            check_output("model_q", 32'(Q), 32'(m_q));
            check_output("model_busy", 32'(busy), 32'(m_busy));
            check_output("model_last_id", 32'(last_id), 32'(m_last));
            check_output("grant_ack_overlap", 32'(grant & ack), 32'd0);
            check_output("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        end
    end

    task automatic set_slices(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        wdata = {s3, s2, s1, s0};
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] exp_q3 [5];
    int         exp_id3 [5];
    int         exp_id6 [6];

    initial begin
        exp_q3  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        exp_id3 = '{0, 1, 2, 3, 0};
        exp_id6 = '{0, 0, 0, 0, 1, 0};

        Reset = 1'b1;
        req   = '0;
        wdata = '0;
        lock  = '0;
        repeat (2) @(negedge Clock);
        check_output("rst_q", 32'(Q), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_grant", 32'(grant), 32'h0);
        Reset = 1'b0;
        @(negedge Clock);

        // Single requester 0 with 0xA5.
        set_slices(8'hA5, 8'h00, 8'h00, 8'h00);
        req = 4'b0001;
        @(negedge Clock);
        check_output("single_grant", 32'(grant), 32'h1);
        check_output("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        @(negedge Clock);
        check_output("single_q", 32'(Q), 32'hA5);
        @(negedge Clock);
        check_output("single_ack", 32'(ack), 32'h1);
        check_output("single_busy_low", 32'(busy), 32'h0);
        @(negedge Clock);
        check_output("single_ack_clear", 32'(ack), 32'h0);

        // Load 0x5A via requester 1, start another write, reset mid-WRITE.
        set_slices(8'hA5, 8'h5A, 8'h00, 8'h00);
        req = 4'b0010;
        @(negedge Clock);
        req = 4'b0000;
        @(negedge Clock);
        check_output("pre_rst_q", 32'(Q), 32'h5A);
        @(negedge Clock);
        req = 4'b0010;
        @(negedge Clock);
        check_output("pre_rst_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        #2 Reset = 1'b1;
        #1;
        check_output("async_rst_q", 32'(Q), 32'h0);
        check_output("async_rst_grant", 32'(grant), 32'h0);
        check_output("async_rst_ack", 32'(ack), 32'h0);
        check_output("async_rst_busy", 32'(busy), 32'h0);
        check_output("async_rst_last_id", 32'(last_id), 32'h0);
        #1 Reset = 1'b0;
        @(negedge Clock);

        // All four requesting continuously.
        set_slices(8'h10, 8'h21, 8'h32, 8'h43);
        req = 4'b1111;
        @(negedge Clock);
        for (int t = 0; t < 5; t++) begin
            @(negedge Clock);
            check_output("all_q", 32'(Q), 32'(exp_q3[t]));
            check_output("all_last_id", 32'(last_id), 32'(exp_id3[t]));
            if (t < 4) repeat (2) @(negedge Clock);
        end
        req = 4'b0000;
        repeat (2) @(negedge Clock);

        // Requester 2 alone moves ptr to 3, then 0101 wraps to 0, then 2.
        req = 4'b0100;
        @(negedge Clock);
        req = 4'b0000;
        repeat (2) @(negedge Clock);
        req = 4'b0101;
        @(negedge Clock);
        check_output("wrap_grant0", 32'(grant), 32'h1);
        @(negedge Clock);
        check_output("wrap_last0", 32'(last_id), 32'h0);
        repeat (3) @(negedge Clock);
        check_output("wrap_last2", 32'(last_id), 32'h2);
        req = 4'b0000;
        @(negedge Clock);
        req = 4'b1111;
        @(negedge Clock);
        check_output("ptr_is_3", 32'(grant), 32'h8);
        req = 4'b0000;
        repeat (2) @(negedge Clock);

        // Requester 1 pulses req for only the arbitration cycle.
        set_slices(8'h10, 8'h7E, 8'h32, 8'h43);
        req = 4'b0010;
        @(negedge Clock);
        req = 4'b0000;
        @(negedge Clock);
        check_output("drop_q", 32'(Q), 32'h7E);
        @(negedge Clock);
        check_output("drop_ack", 32'(ack), 32'h2);
        @(negedge Clock);

`ifdef REG_BANK_ARB_LOCK_EN
        // Locked burst: four writes by 0, then 1, then 0.
        req  = 4'b0011;
        lock = 4'b0001;
        @(negedge Clock);
        for (int t = 0; t < 6; t++) begin
            @(negedge Clock);
            check_output("lock_last_id", 32'(last_id), 32'(exp_id6[t]));
            if (t < 5) repeat (2) @(negedge Clock);
        end
        req  = 4'b0000;
        lock = 4'b0000;
        repeat (2) @(negedge Clock);
`endif

        repeat (2) @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
